// File: rtl/instr_encoder.sv
// instr_encoder: packs ARM instruction requests into 32-bit words and writes them to consecutive addresses.
// Defining ENCODER_CMD_CHECK_EN rejects DP requests whose cmd is not ADD/SUB/AND/ORR.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int MAX_WORDS = 256,
    localparam int CW = (MAX_WORDS > 0) ? $clog2(MAX_WORDS + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_imm,
    input  logic              in_load,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [11:0]       in_imm12,
    input  logic [23:0]       in_imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic              mem_ack,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        load;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [31:0]       wd_q, wd_d, enc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d, legal;

    assign full     = count_q == CW'(MAX_WORDS);
    assign in_ready = state_q == IDLE && !full;
    assign mem_we   = state_q == WR;
    assign mem_addr = addr_q;
    assign mem_wd   = wd_q;
    assign count    = count_q;
    assign err      = err_q;

    always_comb begin
        enc = req_q.kind == 2'b00 ? {req_q.cond, 2'b00, req_q.imm, req_q.cmd, req_q.s, req_q.rn, req_q.rd,
                                     req_q.imm ? req_q.imm12 : {8'b0, req_q.rm}}
            : req_q.kind == 2'b01 ? {req_q.cond, 7'b0101100, req_q.load, req_q.rn, req_q.rd, req_q.imm12}
            : {req_q.cond, 4'b1010, req_q.imm24};
`ifdef ENCODER_CMD_CHECK_EN
        legal = req_q.kind != 2'b11 && (req_q.kind != 2'b00 || req_q.cmd == 4'b0100 || req_q.cmd == 4'b0010
                                        || req_q.cmd == 4'b0000 || req_q.cmd == 4'b1100);
`else
        legal = req_q.kind != 2'b11;
`endif
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                req_d   = '{in_kind, in_cond, in_cmd, in_s, in_imm, in_load, in_rd, in_rn, in_rm, in_imm12, in_imm24};
                state_d = ENC;
            end
            ENC: begin
                wd_d    = legal ? enc : wd_q;
                err_d   = err_q | !legal;
                state_d = legal ? WR : IDLE;
            end
            WR: if (mem_ack) begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + CW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wd_q    <= '0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors, randomized requests against an arithmetic model, and corner sequences.
module tb_instr_encoder;
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        load;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } req_t;
    typedef struct {
        req_t        r;
        logic [31:0] w;
        logic        legal;
        int          stall;
        string       nm;
    } vec_t;

    logic        clk = 0;
    logic        reset, reset2, in_valid, in_valid2, mem_ack, mem_ack2;
    req_t        cur;
    logic        in_ready, mem_we, full, err, in_ready2, mem_we2, full2, err2;
    logic [31:0] mem_addr, mem_wd, mem_addr2, mem_wd2;
    logic [8:0]  count;
    logic [1:0]  count2;

    int          checks = 0, failures = 0;
    logic [31:0] exp_addr;
    int          exp_count;
    logic        exp_err;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(cur.kind), .in_cond(cur.cond), .in_cmd(cur.cmd), .in_s(cur.s), .in_imm(cur.imm),
        .in_load(cur.load), .in_rd(cur.rd), .in_rn(cur.rn), .in_rm(cur.rm), .in_imm12(cur.imm12),
        .in_imm24(cur.imm24), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ack(mem_ack),
        .count(count), .full(full), .err(err)
    );

    instr_encoder #(.MAX_WORDS(2), .BASE_ADDR(32'h100)) dut2 (
        .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_kind(cur.kind), .in_cond(cur.cond), .in_cmd(cur.cmd), .in_s(cur.s), .in_imm(cur.imm),
        .in_load(cur.load), .in_rd(cur.rd), .in_rn(cur.rn), .in_rm(cur.rm), .in_imm12(cur.imm12),
        .in_imm24(cur.imm24), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_ack(mem_ack2),
        .count(count2), .full(full2), .err(err2)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [1:0] k, input logic [3:0] c, input logic [3:0] cm,
                                input logic s, input logic im, input logic ld,
                                input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                input logic [11:0] i12, input logic [23:0] i24);
        mk = '{k, c, cm, s, im, ld, rd, rn, rm, i12, i24};
    endfunction

    function automatic req_t rnd_req();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return req_t'(t[$bits(req_t)-1:0]);
    endfunction

    // Reference encoding built from field positions with plain shifts and ORs.
    function automatic void model(input req_t r, output logic [31:0] w, output logic legal);
        logic [31:0] c;
        c = 32'(r.cond) << 28;
        legal = r.kind != 2'd3;
`ifdef ENCODER_CMD_CHECK_EN
        if (r.kind == 2'd0 && !(r.cmd inside {4'd4, 4'd2, 4'd0, 4'd12})) legal = 1'b0;
`endif
        case (r.kind)
            2'd0: w = c | (32'(r.imm) << 25) | (32'(r.cmd) << 21) | (32'(r.s) << 20) | (32'(r.rn) << 16)
                      | (32'(r.rd) << 12) | (r.imm ? 32'(r.imm12) : 32'(r.rm));
            2'd1: w = c | 32'h0580_0000 | (32'(r.load) << 20) | (32'(r.rn) << 16) | (32'(r.rd) << 12)
                      | 32'(r.imm12);
            2'd2: w = c | 32'h0A00_0000 | 32'(r.imm24);
            default: w = 32'h0;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_req(input req_t r, input logic [31:0] w, input logic legal, input int stall,
                           input string nm);
        wait_ready();
        cur = r;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        cur = rnd_req();
        chk({nm, "_ready_enc"}, in_ready, 0);
        chk({nm, "_we_enc"}, mem_we, 0);
        @(negedge clk);
        if (legal) begin
            chk({nm, "_we"}, mem_we, 1);
            chk({nm, "_addr"}, mem_addr, exp_addr);
            chk({nm, "_wd"}, mem_wd, w);
            chk({nm, "_err"}, err, exp_err);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk({nm, "_stall_we"}, mem_we, 1);
                chk({nm, "_stall_addr"}, mem_addr, exp_addr);
                chk({nm, "_stall_wd"}, mem_wd, w);
                chk({nm, "_stall_ready"}, in_ready, 0);
                chk({nm, "_stall_count"}, count, exp_count);
            end
            mem_ack = 1;
            @(negedge clk);
            mem_ack = 0;
            exp_addr += 4;
            exp_count++;
            chk({nm, "_we_done"}, mem_we, 0);
            chk({nm, "_count"}, count, exp_count);
            chk({nm, "_addr_next"}, mem_addr, exp_addr);
            chk({nm, "_ready_done"}, in_ready, 1);
        end else begin
            exp_err = 1;
            chk({nm, "_ill_err"}, err, 1);
            chk({nm, "_ill_we"}, mem_we, 0);
            chk({nm, "_ill_ready"}, in_ready, 1);
            chk({nm, "_ill_addr"}, mem_addr, exp_addr);
            chk({nm, "_ill_count"}, count, exp_count);
        end
    endtask

    task automatic reset_mid(input logic ack, input string nm);
        wait_ready();
        cur = mk(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk({nm, "_we_pre"}, mem_we, 1);
        reset = 1;
        mem_ack = ack;
        @(negedge clk);
        reset = 0;
        mem_ack = 0;
        exp_addr = 0;
        exp_count = 0;
        exp_err = 0;
        chk({nm, "_we"}, mem_we, 0);
        chk({nm, "_count"}, count, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_wd"}, mem_wd, 0);
        chk({nm, "_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t        v[8];
        req_t        r;
        logic [31:0] w;
        logic        legal;
        int          writes;
        v[0] = '{mk(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 4'd9, 12'h005, 24'hABCDEF), 32'hE2821005, 1'b1, 0, "add"};
        v[1] = '{mk(2'd0, 4'hE, 4'h2, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 4'd4, 12'hFFF, 24'h0), 32'hE0533004, 1'b1, 1, "subs"};
        v[2] = '{mk(2'd1, 4'hE, 4'h7, 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 4'd5, 12'h008, 24'h123456), 32'hE5910008, 1'b1, 2, "ldr"};
        v[3] = '{mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 12'h008, 24'h0), 32'hE5810008, 1'b1, 0, "str"};
        v[4] = '{mk(2'd2, 4'hE, 4'hF, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 4'd7, 12'hABC, 24'hFFFFFD), 32'hEAFFFFFD, 1'b1, 5, "b"};
        v[5] = '{mk(2'd3, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 12'h005, 24'h0), 32'h0, 1'b0, 0, "kind11"};
`ifdef ENCODER_CMD_CHECK_EN
        v[6] = '{mk(2'd0, 4'hE, 4'hF, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h0), 32'hE3E00000, 1'b0, 0, "cmdF"};
`else
        v[6] = '{mk(2'd0, 4'hE, 4'hF, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h0), 32'hE3E00000, 1'b1, 0, "cmdF"};
`endif
        v[7] = '{mk(2'd0, 4'h0, 4'hC, 1'b1, 1'b0, 1'b1, 4'd15, 4'd14, 4'd13, 12'h777, 24'h0), 32'h019EF00D, 1'b1, 1, "orrs"};

        reset = 1; reset2 = 1; in_valid = 0; in_valid2 = 0; mem_ack = 0; mem_ack2 = 0; cur = '0;
        exp_addr = 0; exp_count = 0; exp_err = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_ready", in_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);

        foreach (v[i]) run_req(v[i].r, v[i].w, v[i].legal, v[i].stall, v[i].nm);

        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("idle_ack_count", count, exp_count);
        chk("idle_ack_addr", mem_addr, exp_addr);
        chk("idle_ack_we", mem_we, 0);

        for (int i = 0; i < 40; i++) begin
            r = rnd_req();
            model(r, w, legal);
            run_req(r, w, legal, int'($urandom_range(0, 2)), "rnd");
        end

        reset_mid(1'b0, "rst_wr");
        reset_mid(1'b1, "rst_ack");
        run_req(v[0].r, v[0].w, 1'b1, 0, "add_after_rst");

        cur = v[0].r;
        reset2 = 0;
        @(negedge clk);
        chk("m2_rst_ready", in_ready2, 1);
        in_valid2 = 1;
        mem_ack2 = 1;
        writes = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we2 && mem_ack2) begin
                writes++;
                chk("m2_wd", mem_wd2, 32'hE2821005);
            end
        end
        in_valid2 = 0;
        mem_ack2 = 0;
        chk("m2_writes", writes, 2);
        chk("m2_full", full2, 1);
        chk("m2_ready", in_ready2, 0);
        chk("m2_count", count2, 2);
        chk("m2_addr", mem_addr2, 32'h108);
        chk("m2_err", err2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
